parking_sensor_gen: RTL and testbench
=====================================

# parking_sensor_gen

Stimulus generator that produces the two photo-sensor signals `a`/`b` a car creates when it passes the parking gate. It accepts one enter or exit request at a time and plays the matching four-phase sensor pattern with programmable phase length, so the gate decoder FSM can be driven on the board or in closed-loop tests. It sits upstream of the decoder: its `a`/`b` outputs connect directly to the decoder's `a`/`b` inputs.

## Interface
- `PHASE_CYCLES`, 4: clock cycles each sensor pattern is held; legal range 1 .. 2^PHASE_W−1.
- `PHASE_W`, 8: width of the phase timer.
- `CAPACITY`, 15: lot capacity. Used only with OCCUPANCY_EN.
- `CNT_W`, 4: width of the occupancy count; must hold CAPACITY. Used only with OCCUPANCY_EN.

- `clk` input 1: clock, all state updates on rising edge.
- `reset` input 1: asynchronous, active-high.
- `req_valid` input 1: request present.
- `req_dir` input 1: 0 = enter, 1 = exit; sampled with the request.
- `req_ready` output 1: generator can accept a request this cycle.
- `a` output 1: sensor A, registered.
- `b` output 1: sensor B, registered.
- `busy` output 1: sequence in progress (state ≠ IDLE).
- `done` output 1: one-cycle pulse, sequence complete.
- `count` output CNT_W: cars inside. Present only with OCCUPANCY_EN.

## Operation
- States: IDLE, PH1, PH2, PH3, GAP.
- Reset values: state IDLE, `a`=0, `b`=0, `done`=0, `busy`=0, timer 0, `count`=0, latched direction 0.
- `req_ready` = (state == IDLE) AND the occupancy check passes. It is combinational from registered state.
- Accept: `req_valid && req_ready` at a rising edge. Latch `req_dir`, load timer with PHASE_CYCLES−1, go to PH1.
- `a`/`b` are registered and reflect the state entered at each edge:
  - Enter sequence: PH1=10, PH2=11, PH3=01, GAP=00.
  - Exit sequence: PH1=01, PH2=11, PH3=10, GAP=00.
  - IDLE=00.
- Each of PH1, PH2, PH3 and GAP lasts exactly PHASE_CYCLES cycles.
  - Timer counts down. At 0, advance to the next state and reload the timer.
  - GAP at 0 goes to IDLE.
- `done` is registered and is 1 only in the first IDLE cycle after GAP.
- A request may be accepted in the `done` cycle. Back-to-back cars then have GAP (00 for PHASE_CYCLES cycles) plus one IDLE cycle between patterns.
- `req_valid` and `req_dir` are ignored while busy. A request held through busy is accepted on return to IDLE.
- PHASE_CYCLES=1: each phase lasts one cycle, and the sequence occupies 4 cycles plus the IDLE cycle.
- A reset asserted mid-sequence immediately forces `a`=`b`=0 and state IDLE. No `done` is generated and no count update occurs.

## Timing
- Acceptance edge = E0. Cycle k is the cycle after edge Ek, with N = PHASE_CYCLES.
- PH1 occupies cycles 1..N.
- PH2 occupies cycles N+1..2N.
- PH3 occupies cycles 2N+1..3N.
- GAP occupies cycles 3N+1..4N.
- `done`=1 and `req_ready`=1 in cycle 4N+1.
- Latency from request to first sensor change: 1 cycle.
- Latency from request to `done`: 4N+1 cycles.
- `busy`=1 exactly in cycles 1..4N.

## Configuration
- `OCCUPANCY_EN` defined:
  - `count` port is present.
  - `count` increments by 1 on completion of an enter sequence and decrements by 1 on completion of an exit sequence. The update takes effect at the same edge that raises `done`.
  - `req_ready` is low in IDLE when `req_dir`=0 and `count`==CAPACITY.
  - `req_ready` is low in IDLE when `req_dir`=1 and `count`==0.
  - As a result, `count` never wraps.
- `OCCUPANCY_EN` undefined:
  - No `count` port and no counter logic.
  - `req_ready` = (state == IDLE).

## Test plan
- Enter sequence, N=4: reset, then `req_valid`=1, `req_dir`=0 for one cycle → `ab`=10 in cycles 1–4, 11 in 5–8, 01 in 9–12, 00 in 13–16, `done`=1 only in cycle 17. The downstream decoder pulses `enter` once.
- Exit sequence, N=4: `req_dir`=1 → 01, 11, 10, 00 with the same cycle boundaries, `done` in cycle 17. The decoder pulses `exit` once.
- Back-to-back: `req_valid` held high with `req_dir`=0, N=2 → second PH1 (`ab`=10) begins in cycle 10. `done` pulses in cycles 9 and 18. Requests presented during busy are not accepted twice.
- Reset mid-sequence: assert reset in cycle 6 of an enter sequence → `a`=`b`=0 and `busy`=0 within the same cycle. No `done` pulse. The next request starts a clean PH1.
- N=1 boundary: enter request → `ab`=10, 11, 01, 00 in cycles 1–4, `done` in cycle 5.
- OCCUPANCY_EN, CAPACITY=2:
  - Exit request at `count`=0 → `req_ready`=0 and `ab` stays 00.
  - Three enter requests → `count`=1, then 2. The third request is held off with `req_ready`=0.
  - One exit request → `count`=1.

Source files
------------

// File: rtl/parking_sensor_gen.sv
// parking_sensor_gen: generates the four-phase a/b photo-sensor pattern of a car
// entering or leaving the lot. Define OCCUPANCY_EN to add the occupancy counter.
module parking_sensor_gen #(
    parameter int PHASE_CYCLES = 4,
    parameter int PHASE_W      = 8,
    parameter int CAPACITY     = 15,
    parameter int CNT_W        = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic req_valid,
    input  logic req_dir,
    output logic req_ready,
    output logic a,
    output logic b,
    output logic busy,
    output logic done
`ifdef OCCUPANCY_EN
    ,
    output logic [CNT_W-1:0] count
`endif
);
    typedef enum logic [2:0] {IDLE, PH1, PH2, PH3, GAP} state_t;

    localparam logic [PHASE_W-1:0] PhaseLoad = PHASE_W'(PHASE_CYCLES - 1);

    if (PHASE_CYCLES < 1 || PHASE_CYCLES > (2**PHASE_W) - 1 ||
        CAPACITY < 1 || CAPACITY > (2**CNT_W) - 1) begin : gBadParams
        $error("parking_sensor_gen: illegal parameter combination");
    end

    state_t             state_q, state_d;
    logic [PHASE_W-1:0] timer_q;
    logic               dir_q, a_q, b_q, done_q;
    logic               occupancyOk;
    logic               accept;

    // Sensor levels for a state; direction only swaps the outer phases.
    function automatic logic [1:0] patternFor(state_t s, logic dir);
        case (s)
            PH1:     patternFor = dir ? 2'b01 : 2'b10;
            PH2:     patternFor = 2'b11;
            PH3:     patternFor = dir ? 2'b10 : 2'b01;
            default: patternFor = 2'b00;
        endcase
    endfunction

    always_comb begin
        case (state_q)
            PH1:     state_d = PH2;
            PH2:     state_d = PH3;
            PH3:     state_d = GAP;
            default: state_d = IDLE;
        endcase
    end

`ifdef OCCUPANCY_EN
    logic [CNT_W-1:0] count_q;

    // Refuse an entry into a full lot and an exit from an empty one.
    assign occupancyOk = req_dir ? (count_q != '0) : (count_q != CNT_W'(CAPACITY));
    assign count       = count_q;
`else
    assign occupancyOk = 1'b1;
`endif

    assign req_ready = (state_q == IDLE) && occupancyOk;
    assign accept    = req_valid && req_ready;
    assign busy      = (state_q != IDLE);
    assign a         = a_q;
    assign b         = b_q;
    assign done      = done_q;

    // Each phase holds for PhaseLoad+1 cycles; leaving GAP raises done and
    // commits the occupancy change on the same edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            timer_q <= '0;
            dir_q   <= 1'b0;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
            done_q  <= 1'b0;
`ifdef OCCUPANCY_EN
            count_q <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            if (state_q == IDLE) begin
                if (accept) begin
                    dir_q      <= req_dir;
                    timer_q    <= PhaseLoad;
                    state_q    <= PH1;
                    {a_q, b_q} <= patternFor(PH1, req_dir);
                end
            end else if (timer_q == '0) begin
                timer_q    <= PhaseLoad;
                state_q    <= state_d;
                {a_q, b_q} <= patternFor(state_d, dir_q);
                if (state_q == GAP) begin
                    done_q <= 1'b1;
`ifdef OCCUPANCY_EN
                    if (dir_q) begin
                        count_q <= count_q - CNT_W'(1);
                    end else begin
                        count_q <= count_q + CNT_W'(1);
                    end
`endif
                end
            end else begin
                timer_q <= timer_q - PHASE_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_parking_sensor_gen.sv
// Scoreboard bench for parking_sensor_gen: expected per-cycle a/b/busy/done/ready
// values are queued when a request is driven and compared every cycle.
module tb_parking_sensor_gen;
`ifdef OCCUPANCY_EN
    localparam int NI = 4;
`else
    localparam int NI = 3;
`endif

    typedef struct packed {
        logic [1:0] ab;
        logic       busy;
        logic       done;
        logic       ready;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          reqValid;
    logic          reqDir;
    int            sel;
    logic [NI-1:0] aW, bW, busyW, doneW, readyW;
`ifdef OCCUPANCY_EN
    logic [3:0]    cntW [NI];
`endif

    int   checks = 0;
    int   errors = 0;
    exp_t expQ[$];

    always #5 clk = ~clk;

    parking_sensor_gen #(.PHASE_CYCLES(4)) u0 (
        .clk(clk), .reset(reset), .req_valid(reqValid && sel == 0), .req_dir(reqDir),
        .req_ready(readyW[0]), .a(aW[0]), .b(bW[0]), .busy(busyW[0]), .done(doneW[0])
`ifdef OCCUPANCY_EN
        , .count(cntW[0])
`endif
    );
    parking_sensor_gen #(.PHASE_CYCLES(2)) u1 (
        .clk(clk), .reset(reset), .req_valid(reqValid && sel == 1), .req_dir(reqDir),
        .req_ready(readyW[1]), .a(aW[1]), .b(bW[1]), .busy(busyW[1]), .done(doneW[1])
`ifdef OCCUPANCY_EN
        , .count(cntW[1])
`endif
    );
    parking_sensor_gen #(.PHASE_CYCLES(1)) u2 (
        .clk(clk), .reset(reset), .req_valid(reqValid && sel == 2), .req_dir(reqDir),
        .req_ready(readyW[2]), .a(aW[2]), .b(bW[2]), .busy(busyW[2]), .done(doneW[2])
`ifdef OCCUPANCY_EN
        , .count(cntW[2])
`endif
    );
`ifdef OCCUPANCY_EN
    parking_sensor_gen #(.PHASE_CYCLES(1), .CAPACITY(2)) u3 (
        .clk(clk), .reset(reset), .req_valid(reqValid && sel == 3), .req_dir(reqDir),
        .req_ready(readyW[3]), .a(aW[3]), .b(bW[3]), .busy(busyW[3]), .done(doneW[3]),
        .count(cntW[3])
    );
`endif

    function automatic exp_t getObs();
        exp_t o;
        o.ab    = {aW[sel], bW[sel]};
        o.busy  = busyW[sel];
        o.done  = doneW[sel];
        o.ready = readyW[sel];
        return o;
    endfunction

    function automatic logic [1:0] abOf(int phase, logic dir);
        logic [1:0] r;
        case (phase)
            0:       r = dir ? 2'b01 : 2'b10;
            1:       r = 2'b11;
            2:       r = dir ? 2'b10 : 2'b01;
            default: r = 2'b00;
        endcase
        return r;
    endfunction

    task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Expected cycles 1..4N+1 of one sequence, done cycle last.
    task automatic pushSequence(input int n, input logic dir, input logic doneReady);
        for (int k = 0; k < 4 * n; k++) begin
            expQ.push_back('{ab: abOf(k / n, dir), busy: 1'b1, done: 1'b0, ready: 1'b0});
        end
        expQ.push_back('{ab: 2'b00, busy: 1'b0, done: 1'b1, ready: doneReady});
    endtask

    task automatic pushIdle(input int cycles, input logic rdy);
        for (int k = 0; k < cycles; k++) begin
            expQ.push_back('{ab: 2'b00, busy: 1'b0, done: 1'b0, ready: rdy});
        end
    endtask

    task automatic compareFront(input string tag);
        exp_t e;
        e = expQ.pop_front();
        checkOutput(tag, 8'(getObs()), 8'(e));
    endtask

    task automatic drainQueue(input string tag);
        int guard;
        guard = 0;
        while (expQ.size() > 0 && guard < 500) begin
            compareFront(tag);
            @(posedge clk);
            #1;
            guard++;
        end
    endtask

    // Presents one request for a single edge and queues what should follow it.
    task automatic applyStimulus(input int n, input logic dir, input logic doneReady);
        reqValid = 1'b1;
        reqDir   = dir;
        pushSequence(n, dir, doneReady);
        pushIdle(1, doneReady);
        @(posedge clk);
        #1;
        reqValid = 1'b0;
        reqDir   = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset    = 1'b1;
        reqValid = 1'b0;
        reqDir   = 1'b0;
        sel      = 0;
        repeat (2) @(posedge clk);
        #1;
        for (int s = 0; s < NI; s++) begin
            sel = s;
            #0;
            checkOutput("reset", 8'(getObs()), 8'({2'b00, 1'b0, 1'b0, 1'b1}));
`ifdef OCCUPANCY_EN
            checkOutput("resetCount", 8'(cntW[s]), 8'd0);
`endif
        end
        reset = 1'b0;
        @(posedge clk);
        #1;

        sel = 0;
        applyStimulus(4, 1'b0, 1'b1);
        drainQueue("enterN4");
        applyStimulus(4, 1'b1, 1'b1);
        drainQueue("exitN4");

        // Request held high through two complete sequences on the N=2 unit.
        sel      = 1;
        reqValid = 1'b1;
        reqDir   = 1'b0;
        pushSequence(2, 1'b0, 1'b1);
        pushSequence(2, 1'b0, 1'b1);
        pushIdle(2, 1'b1);
        @(posedge clk);
        #1;
        for (int k = 1; k <= 20; k++) begin
            compareFront("backToBack");
            @(posedge clk);
            #1;
            if (k == 9) begin
                reqValid = 1'b0;
            end
        end

        // Reset in cycle 6 of an enter sequence.
        sel = 0;
        applyStimulus(4, 1'b0, 1'b1);
        for (int k = 1; k <= 5; k++) begin
            compareFront("preReset");
            @(posedge clk);
            #1;
        end
        compareFront("preReset");
        #1;
        reset = 1'b1;
        #1;
        checkOutput("midReset", 8'(getObs()), 8'({2'b00, 1'b0, 1'b0, 1'b1}));
        reset = 1'b0;
        expQ.delete();
        @(posedge clk);
        #1;
        pushIdle(4, 1'b1);
        drainQueue("afterReset");
        applyStimulus(4, 1'b0, 1'b1);
        drainQueue("cleanRestart");

        sel = 2;
        applyStimulus(1, 1'b0, 1'b1);
        drainQueue("enterN1");

`ifdef OCCUPANCY_EN
        sel      = 3;
        reqValid = 1'b1;
        reqDir   = 1'b1;
        #1;
        checkOutput("exitEmptyReady", 8'(readyW[3]), 8'd0);
        @(posedge clk);
        #1;
        checkOutput("exitEmptyIdle", 8'(getObs()), 8'({2'b00, 1'b0, 1'b0, 1'b0}));
        reqValid = 1'b0;
        reqDir   = 1'b0;
        applyStimulus(1, 1'b0, 1'b1);
        drainQueue("occEnter1");
        checkOutput("count1", 8'(cntW[3]), 8'd1);
        applyStimulus(1, 1'b0, 1'b0);
        drainQueue("occEnter2");
        checkOutput("count2", 8'(cntW[3]), 8'd2);
        reqValid = 1'b1;
        #1;
        checkOutput("fullReady", 8'(readyW[3]), 8'd0);
        @(posedge clk);
        #1;
        checkOutput("fullIdle", 8'(getObs()), 8'({2'b00, 1'b0, 1'b0, 1'b0}));
        reqValid = 1'b0;
        applyStimulus(1, 1'b1, 1'b1);
        drainQueue("occExit");
        checkOutput("countBack1", 8'(cntW[3]), 8'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
